vec_dot_accum: RTL and testbench

Downstream stage of the 5-bit element-index counter in the 16x16 pipelined vector multiplier. Consumes the counter's index together with one operand pair per cycle and multiplies the pair in a registered product stage. It accumulates the products over one vector of N_ELEM elements and presents the dot product on a valid/ready result port.

---
 rtl/vec_dot_accum.sv | 91 +++++++++
 tb/tb_vec_dot_accum.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_dot_accum.sv
// vec_dot_accum: registered element multiply, dot-product accumulate, result port.
// clk/rstn; valid_i,count_i,a_i,b_i in; result_o,result_valid_o,result_ready_i,overrun_o.
module vec_dot_accum #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 16,
  localparam int ACC_W = 2*DATA_W+5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_i,
  input  logic [4:0]        count_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              overrun_o
);

  localparam int PW = 2*DATA_W;
  localparam logic [4:0] LAST = 5'(N_ELEM-1);

  logic          in_range;
  logic          accept;
  logic [PW-1:0] mul;

  logic          p_valid;
  logic [PW-1:0] prod;
  logic [4:0]    tag;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  logic done;
  logic done_q;
  logic hs;
  logic load;

  assign in_range = {1'b0, count_i} < 6'(N_ELEM);
  assign accept   = valid_i && in_range;
  assign mul      = PW'(a_i) * PW'(b_i);

  // Index 0 always starts a fresh sum,
  // discarding any partial vector.
  assign acc_next = (tag == 5'd0)
                  ? ACC_W'(prod)
                  : acc + ACC_W'(prod);

  assign done = p_valid && (tag == LAST);
  assign hs   = result_valid_o && result_ready_i;

  // Completed sum sits in acc for one cycle;
  // it is offered to the result port then.
  assign load = done_q &&
                (!result_valid_o || result_ready_i);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      p_valid        <= 1'b0;
      prod           <= '0;
      tag            <= '0;
      acc            <= '0;
      done_q         <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        prod <= mul;
        tag  <= count_i;
      end

      if (p_valid)
        acc <= acc_next;
      done_q <= done;

      if (load) begin
        result_o       <= acc;
        result_valid_o <= 1'b1;
      end else if (hs) begin
        result_valid_o <= 1'b0;
      end

      if (done_q && result_valid_o &&
          !result_ready_i)
        overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_dot_accum.sv
// tb_vec_dot_accum: scoreboard bench for vec_dot_accum.
// Drives N_ELEM=16 and N_ELEM=32 instances from shared stimulus.
module tb_vec_dot_accum;

  localparam int DW = 8;
  localparam int AW = 2*DW+5;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          valid = 1'b0;
  logic [4:0]    cnt = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          ready = 1'b0;
  logic          ready32 = 1'b1;

  logic [AW-1:0] res;
  logic [AW-1:0] res32;
  logic          rv;
  logic          rv32;
  logic          ovr;
  logic          ovr32;

  int checks = 0;
  int errors = 0;
  int mac16 = 0;
  int mac32 = 0;
  int q[$];
  int q32[$];

  always #5 clk = ~clk;

  vec_dot_accum #(.DATA_W(DW), .N_ELEM(16)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid),
    .count_i(cnt), .a_i(a), .b_i(b),
    .result_o(res), .result_valid_o(rv),
    .result_ready_i(ready), .overrun_o(ovr)
  );

  vec_dot_accum #(.DATA_W(DW), .N_ELEM(32)) dut32 (
    .clk(clk), .rstn(rstn), .valid_i(valid),
    .count_i(cnt), .a_i(a), .b_i(b),
    .result_o(res32), .result_valid_o(rv32),
    .result_ready_i(ready32), .overrun_o(ovr32)
  );

  task automatic elem(input int c, input int av,
                      input int bv);
    @(negedge clk);
    valid = 1'b1;
    cnt = 5'(c);
    a = DW'(av);
    b = DW'(bv);
    if (c < 16) begin
      if (c == 0) mac16 = av*bv;
      else mac16 += av*bv;
      if (c == 15) q.push_back(mac16);
    end
    if (c < 32) begin
      if (c == 0) mac32 = av*bv;
      else mac32 += av*bv;
      if (c == 31) q32.push_back(mac32);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    q32.delete();
    mac16 = 0;
    mac32 = 0;
  endtask

  task automatic wait_rv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rv) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (res !== '0) begin
      errors++;
      $display("FAIL reset_result got %0d want 0", res);
    end
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", rv);
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun got %0b want 0", ovr);
    end
  endtask

  task automatic test_basic();
    int exp;
    ready = 1'b1;
    for (int k = 0; k < 16; k++) elem(k, k+1, 2);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got %0b want 0", rv);
    end
    @(negedge clk);
    checks++;
    if (rv !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid got %0b want 1", rv);
    end
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (res !== AW'(exp)) begin
      errors++;
      $display("FAIL basic_model got %0d want %0d", res, exp);
    end
    checks++;
    if (res !== AW'(272)) begin
      errors++;
      $display("FAIL basic_value got %0d want 272", res);
    end
    @(negedge clk);
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse got %0b want 0", rv);
    end
  endtask

  task automatic test_max();
    int exp;
    bit ok;
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 32; k++) elem(k, 255, 255);
    idle(1);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rv32) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL max_timeout got 0 want 1");
    end
    exp = (q32.size() > 0) ? q32.pop_front() : -1;
    checks++;
    if (res32 !== AW'(exp)) begin
      errors++;
      $display("FAIL max_model got %0d want %0d", res32, exp);
    end
    checks++;
    if (res32 !== 21'd2080800) begin
      errors++;
      $display("FAIL max_value got %0d want 2080800", res32);
    end
    q.delete();
  endtask

  task automatic test_backpressure();
    int exp;
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 16; k++) elem(k, 1, 1);
    for (int k = 0; k < 16; k++) elem(k, 1, 2);
    idle(7);
    exp = (q.size() > 0) ? q[0] : -1;
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun got %0b want 1", ovr);
    end
    checks++;
    if (rv !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid got %0b want 1", rv);
    end
    checks++;
    if (res !== AW'(exp)) begin
      errors++;
      $display("FAIL bp_model got %0d want %0d", res, exp);
    end
    @(negedge clk);
    ready = 1'b1;
    checks++;
    if (res !== AW'(16)) begin
      errors++;
      $display("FAIL bp_accept got %0d want 16", res);
    end
    @(negedge clk);
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %0b want 0", rv);
    end
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky got %0b want 1", ovr);
    end
    q.delete();
  endtask

  task automatic test_simul();
    int exp;
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 16; k++) elem(k, k, 1);
    for (int k = 0; k < 16; k++) elem(k, 2, 3);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (rv !== 1'b1 || res !== AW'(exp)) begin
      errors++;
      $display("FAIL sim_first got %0b/%0d want 1/%0d",
               rv, res, exp);
    end
    @(negedge clk);
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (rv !== 1'b1) begin
      errors++;
      $display("FAIL sim_valid got %0b want 1", rv);
    end
    checks++;
    if (res !== AW'(exp)) begin
      errors++;
      $display("FAIL sim_second got %0d want %0d", res, exp);
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL sim_overrun got %0b want 0", ovr);
    end
    @(negedge clk);
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL sim_drain got %0b want 0", rv);
    end
  endtask

  task automatic test_restart();
    int exp;
    bit ok;
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 8; k++) elem(k, 5, 5);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) elem(20, 200, 200);
      elem(k, k+3, 7);
      if (k % 3 == 0) idle(1);
    end
    idle(1);
    wait_rv(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_timeout got 0 want 1");
    end
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (res !== AW'(exp)) begin
      errors++;
      $display("FAIL restart_model got %0d want %0d", res, exp);
    end
    checks++;
    if (res !== AW'(1176)) begin
      errors++;
      $display("FAIL restart_value got %0d want 1176", res);
    end
  endtask

  task automatic test_reset_mid();
    int exp;
    bit ok;
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 32; k++) elem(k % 16, 1, 1);
    idle(3);
    checks++;
    if (rv !== 1'b1 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %0b/%0b want 1/1", rv, ovr);
    end
    for (int k = 0; k < 10; k++) elem(k, 3, 4);
    do_reset();
    checks++;
    if (res !== '0) begin
      errors++;
      $display("FAIL mid_result got %0d want 0", res);
    end
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL mid_valid got %0b want 0", rv);
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL mid_overrun got %0b want 0", ovr);
    end
    ready = 1'b1;
    for (int k = 0; k < 16; k++) elem(k, k, k);
    idle(1);
    wait_rv(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_timeout got 0 want 1");
    end
    exp = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (res !== AW'(exp)) begin
      errors++;
      $display("FAIL mid_model got %0d want %0d", res, exp);
    end
    checks++;
    if (res !== AW'(1240)) begin
      errors++;
      $display("FAIL mid_value got %0d want 1240", res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_simul();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
